// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared GLB widths, data/loader enums and bank decode helper
package shared_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 17;
  localparam int NUM_BANKS  = 4;

  typedef enum logic [1:0] {
    IFMAP  = 2'd0,
    FILTER = 2'd1,
    BIAS   = 2'd2,
    PSUM   = 2'd3
  } data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  // One-hot bank enable for a flat word address; the bank is the low two bits.
  function automatic logic [NUM_BANKS-1:0] bank_of(input logic [ADDR_WIDTH-1:0] addr);
    return NUM_BANKS'(1) << addr[1:0];
  endfunction

endpackage

// File: rtl/glb_addr_gen.sv
// rtl/glb_addr_gen.sv - load address/remaining counters with bank/row split
module glb_addr_gen #(
  parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  input  logic                  step,
  output logic                  last_word,
  output logic [3:0]            bank_onehot,
  output logic [ADDR_WIDTH-3:0] bank_row
);
  import shared_pkg::*;

  logic [ADDR_WIDTH-1:0]            cur_addr;
  logic [ADDR_WIDTH-1:0]            remaining;
  logic [shared_pkg::ADDR_WIDTH-1:0] addr_lo;

  // Address wraps naturally at 2^ADDR_WIDTH; remaining counts down to the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= base_addr;
      remaining <= num_words;
    end else if (step) begin
      cur_addr  <= cur_addr + ADDR_WIDTH'(1);
      remaining <= remaining - ADDR_WIDTH'(1);
    end
  end

  // Only the bank bits feed the decode, so the helper works for any ADDR_WIDTH.
  always_comb begin
    addr_lo     = '0;
    addr_lo[1:0] = cur_addr[1:0];
    bank_onehot = bank_of(addr_lo);
    bank_row    = cur_addr[ADDR_WIDTH-1:2];
    last_word   = (remaining == {{(ADDR_WIDTH-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/glb_stream_loader.sv
// rtl/glb_stream_loader.sv - GLB front-door stream loader, optional GLB_LOADER_CHECKSUM_EN
module glb_stream_loader #(
  parameter int DATA_WIDTH = shared_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_glb,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_num_words,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  wr_stall,
  output logic [1:0]            glb_sel,
  output logic [3:0]            bank_we,
  output logic [ADDR_WIDTH-3:0] bank_addr,
  output logic [DATA_WIDTH-1:0] bank_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);
  import shared_pkg::*;

  loader_state_t         state, state_next;
  data_t                 glb_q;
  logic                  cmd_accept;
  logic                  word_accept;
  logic                  last_word;
  logic [3:0]            bank_onehot;
  logic [ADDR_WIDTH-3:0] bank_row;

  assign cmd_ready   = (state == IDLE);
  assign cmd_accept  = cmd_valid && cmd_ready;
  assign s_ready     = (state == LOAD) && !wr_stall;
  assign word_accept = s_valid && s_ready;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  glb_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (cmd_accept),
    .base_addr  (cmd_base_addr),
    .num_words  (cmd_num_words),
    .step       (word_accept),
    .last_word  (last_word),
    .bank_onehot(bank_onehot),
    .bank_row   (bank_row)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: a zero-length command goes straight to DONE; DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmd_accept) state_next = (cmd_num_words != '0) ? LOAD : DONE;
      LOAD: if (word_accept && last_word) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the target GLB for the whole command.
  always_ff @(posedge clk) begin
    if (rst)             glb_q <= IFMAP;
    else if (cmd_accept) glb_q <= data_t'(cmd_glb);
  end

  // Registered write port: one write the cycle after each accepted word, none otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      glb_sel    <= '0;
    end else begin
      bank_we <= word_accept ? bank_onehot : '0;
      if (word_accept) begin
        bank_addr  <= bank_row;
        bank_wdata <= s_data;
        glb_sel    <= glb_q;
      end
    end
  end

`ifdef GLB_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  // XOR of every accepted word, cleared on command accept and held after done.
  always_ff @(posedge clk) begin
    if (rst)              csum_q <= '0;
    else if (cmd_accept)  csum_q <= '0;
    else if (word_accept) csum_q <= csum_q ^ s_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_glb_stream_loader.sv
// tb/tb_glb_stream_loader.sv - randomized self-checking bench for glb_stream_loader
module tb_glb_stream_loader;

  localparam int DW   = 16;
  localparam int AW   = 17;
  localparam int SPAN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_glb;
  logic [AW-1:0] cmd_base_addr;
  logic [AW-1:0] cmd_num_words;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          wr_stall;
  logic [1:0]    glb_sel;
  logic [3:0]    bank_we;
  logic [AW-3:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  glb_stream_loader dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_glb      (cmd_glb),
    .cmd_base_addr(cmd_base_addr),
    .cmd_num_words(cmd_num_words),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .wr_stall     (wr_stall),
    .glb_sel      (glb_sel),
    .bank_we      (bank_we),
    .bank_addr    (bank_addr),
    .bank_wdata   (bank_wdata),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    we;
    logic [AW-3:0] row;
    logic [DW-1:0] data;
    logic [1:0]    glb;
    bit            last;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [DW-1:0] fixed_q[$];
  bit            mon_en = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_checksum(input logic [DW-1:0] x);
`ifdef GLB_LOADER_CHECKSUM_EN
    return x;
`else
    return '0;
`endif
  endfunction

  // Every write seen on the bank port must be the next one predicted by the model.
  always @(negedge clk) begin
    if (mon_en && bank_we != 4'd0) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_write", bank_we, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("bank_we", bank_we, mon_e.we);
        check_eq("bank_addr", bank_addr, mon_e.row);
        check_eq("bank_wdata", bank_wdata, mon_e.data);
        check_eq("glb_sel", glb_sel, mon_e.glb);
        check_eq("done_with_write", done, mon_e.last);
      end
    end
  end

  // mode 0: s_valid constant; mode 1: random valid/stall and stray commands;
  // mode 2: 3-cycle stall once two words are in. abort_after>0 resets after that many words.
  task automatic run_cmd(input logic [1:0] glb, input int base, input int num,
                         input int mode, input int abort_after);
    logic [DW-1:0] words[$];
    logic [DW-1:0] xr;
    int            flat, idx, cycles, stall_left;
    bit            hs, prev_hs, stalled, aborted;
    wr_t           e;

    xr = '0;
    for (int i = 0; i < num; i++) begin
      if (fixed_q.size() > 0) words.push_back(fixed_q.pop_front());
      else                    words.push_back(DW'($urandom));
      xr ^= words[i];
    end

    // A word offered while idle must be ignored.
    s_valid = 1'b1;
    s_data  = DW'($urandom);
    #1;
    check_eq("idle_s_ready", s_ready, 0);
    check_eq("idle_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    check_eq("idle_no_write", bank_we, 0);
    s_valid = 1'b0;

    for (int i = 0; i < num; i++) begin
      flat   = (base + i) % SPAN;
      e.we   = 4'(1 << (flat % 4));
      e.row  = (AW-2)'(flat / 4);
      e.data = words[i];
      e.glb  = glb;
      e.last = (i == num - 1);
      exp_q.push_back(e);
    end

    cmd_valid     = 1'b1;
    cmd_glb       = glb;
    cmd_base_addr = AW'(base);
    cmd_num_words = AW'(num);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;

    if (num == 0) begin
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 1);
      check_eq("zero_cmd_ready", cmd_ready, 0);
      check_eq("zero_no_write", bank_we, 0);
      check_eq("zero_checksum", checksum, 0);
      @(negedge clk);
      check_eq("zero_done_clear", done, 0);
      check_eq("zero_cmd_ready_back", cmd_ready, 1);
      check_eq("zero_busy_clear", busy, 0);
      return;
    end

    idx = 0; cycles = 0; stall_left = 0;
    prev_hs = 1'b0; stalled = 1'b0; aborted = 1'b0;
    while (idx < num && cycles < 4 * num + 64) begin
      check_eq("we_iff_accepted", bank_we != 4'd0, prev_hs);
      check_eq("load_busy", busy, 1);
      check_eq("load_cmd_ready", cmd_ready, 0);
      if (abort_after > 0 && idx == abort_after) begin
        aborted = 1'b1;
        break;
      end
      case (mode)
        1: begin
          s_valid       = ($urandom_range(0, 3) != 0);
          wr_stall      = ($urandom_range(0, 3) == 0);
          cmd_valid     = $urandom_range(0, 1);
          cmd_glb       = 2'($urandom);
          cmd_base_addr = AW'($urandom);
          cmd_num_words = AW'($urandom);
        end
        2: begin
          if (!stalled && idx == 2) begin
            stall_left = 3;
            stalled    = 1'b1;
          end
          wr_stall = (stall_left > 0);
          if (stall_left > 0) stall_left--;
          s_valid = 1'b1;
        end
        default: begin
          s_valid  = 1'b1;
          wr_stall = 1'b0;
        end
      endcase
      s_data = words[idx];
      #1;
      check_eq("s_ready", s_ready, !wr_stall);
      hs = s_valid && !wr_stall;
      @(posedge clk);
      if (hs) idx++;
      prev_hs = hs;
      cycles++;
      @(negedge clk);
    end

    if (aborted) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_no_write", bank_we, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_cmd_ready", cmd_ready, 1);
      check_eq("rst_done", done, 0);
      check_eq("rst_checksum", checksum, 0);
      rst       = 1'b0;
      s_valid   = 1'b0;
      wr_stall  = 1'b0;
      cmd_valid = 1'b0;
      exp_q.delete();
      return;
    end

    if (idx < num) begin
      check_eq("load_timeout", idx, num);
      s_valid = 1'b0; wr_stall = 1'b0; cmd_valid = 1'b0;
      return;
    end

    check_eq("done_at_last", done, 1);
    check_eq("checksum_at_done", checksum, exp_checksum(xr));
    s_valid   = 1'b0;
    wr_stall  = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("post_done", done, 0);
    check_eq("post_busy", busy, 0);
    check_eq("post_cmd_ready", cmd_ready, 1);
    check_eq("post_no_write", bank_we, 0);
    check_eq("post_s_ready", s_ready, 0);
    check_eq("checksum_held", checksum, exp_checksum(xr));
    check_eq("all_writes_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int base, num;

    rst = 1'b1; cmd_valid = 1'b0; cmd_glb = '0; cmd_base_addr = '0; cmd_num_words = '0;
    s_valid = 1'b0; s_data = '0; wr_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_cmd_ready", cmd_ready, 1);
    check_eq("reset_s_ready", s_ready, 0);
    check_eq("reset_bank_we", bank_we, 0);
    check_eq("reset_bank_addr", bank_addr, 0);
    check_eq("reset_bank_wdata", bank_wdata, 0);
    check_eq("reset_glb_sel", glb_sel, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_checksum", checksum, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    run_cmd(2'd0, 0, 8, 0, 0);
    run_cmd(2'd3, 6, 4, 0, 0);
    run_cmd(2'd1, 100, 0, 0, 0);
    run_cmd(2'd2, 37, 12, 2, 0);
    run_cmd(2'd0, SPAN - 2, 4, 0, 0);
    run_cmd(2'd1, 500, 10, 0, 3);
    fixed_q.push_back(16'h0001);
    fixed_q.push_back(16'h0010);
    fixed_q.push_back(16'h0100);
    run_cmd(2'd2, 9, 3, 0, 0);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) base = SPAN - int'($urandom_range(1, 8));
      else                          base = int'($urandom_range(0, SPAN - 1));
      num = int'($urandom_range(0, 20));
      run_cmd(2'($urandom), base, num, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/glb_stream_loader.md
Name: glb_stream_loader

Overview:
- Front-door loader for the global buffer (GLB).
- Accepts one load command at a time: target GLB, base address and word count. Then consumes a valid/ready word stream and issues one write per word into the target GLB's four interleaved SRAM banks.
- Bank = addr[1:0], bank row = addr>>2.
- Sits between the off-chip/testbench data stream and the IFMAP/FILTER/BIAS/PSUM GLB write ports.

Parameters:
- DATA_WIDTH, 16, GLB word width.
- ADDR_WIDTH, 17, flat GLB word address width (4 banks of 2^(ADDR_WIDTH-2) rows).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  loader idle; command accepted when cmd_valid&&cmd_ready.
- cmd_glb  in  2  target GLB, data_t encoding (IFMAP, FILTER, BIAS, PSUM).
- cmd_base_addr  in  ADDR_WIDTH  first flat word address.
- cmd_num_words  in  ADDR_WIDTH  words to load, 0 allowed.
- s_valid  in  1  stream word present.
- s_ready  out  1  loader accepts s_data this cycle.
- s_data  in  DATA_WIDTH  stream word.
- wr_stall  in  1  GLB write port busy; loader must not accept words.
- glb_sel  out  2  GLB addressed by the current write (data_t).
- bank_we  out  4  one-hot bank write enable, bit k = bank addr[1:0]==k.
- bank_addr  out  ADDR_WIDTH-2  bank row (addr>>2).
- bank_wdata  out  DATA_WIDTH  write data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- checksum  out  DATA_WIDTH  see Optional Feature.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - state=IDLE.
  - Outputs cmd_ready=1, s_ready=0, bank_we=0, bank_addr=0, bank_wdata=0, glb_sel=0, busy=0, done=0, checksum=0.
  - Reset mid-load abandons the command, drops any in-flight word and asserts no write in the following cycle.
- FSM IDLE:
  - cmd_ready=1.
  - On cmd handshake: latch glb, cur_addr=base, remaining=num_words.
  - Go to LOAD if num_words!=0, else DONE.
- FSM LOAD:
  - s_ready = !wr_stall (combinational).
  - On s_valid&&s_ready at edge N:
    - Registered outputs at N+1: bank_we=1<<cur_addr[1:0], bank_addr=cur_addr>>2, bank_wdata=s_data, glb_sel=latched glb.
    - cur_addr+=1, remaining-=1.
  - Throughput 1 word/cycle. Write latency exactly 1 cycle after handshake.
  - When the accepted word is the last (remaining==1): go to DONE. s_ready is 0 from then on.
  - bank_we is 0 in any cycle with no accepted word in the prior cycle.
- FSM DONE:
  - done=1 for exactly one cycle, coincident with the last write's bank_we (or the cycle after the command when num_words==0).
  - Then IDLE.
  - cmd_ready=0 in DONE; a new command can be accepted the cycle after done.
- busy=1 in LOAD and DONE.
- Address wrap: cur_addr increments modulo 2^ADDR_WIDTH. A load crossing 2^ADDR_WIDTH-1 continues at 0 on bank 0, row 0.
- Handshake edge cases:
  - s_valid while IDLE is ignored (s_ready=0).
  - wr_stall rising in the same cycle as s_valid blocks the word; it stays on s_data until accepted.
  - cmd_valid during LOAD is not accepted.
- Bank rotation: consecutive words rotate bank_we 0001→0010→0100→1000 from the base bank. bank_addr increments each time bank 3 is passed.

Optional Feature:
- Macro GLB_LOADER_CHECKSUM_EN.
- Defined:
  - checksum clears on command accept and accumulates the XOR of every accepted word.
  - Final value is valid and held from the done cycle until the next command accept.
- Undefined: checksum port exists and is constant 0; no accumulator logic.

Decomposition:
- shared_pkg holds DATA_WIDTH, ADDR_WIDTH, NUM_BANKS=4, and the data_t enum (IFMAP, FILTER, BIAS, PSUM).
- Add to shared_pkg: loader state enum {IDLE, LOAD, DONE} and function bank_of(addr) returning the one-hot 4-bit enable.
- One natural sub-module: glb_addr_gen (cur_addr/remaining counters, last-word flag, bank/row split), instantiated once.

Test Plan:
- cmd IFMAP, base 0, num 8, s_valid constant → 8 writes on consecutive cycles.
  - bank_we 1,2,4,8,1,2,4,8; bank_addr 0,0,0,0,1,1,1,1.
  - done pulses with the 8th write; busy drops next cycle.
- cmd PSUM, base 6, num 4 → bank_we 4,8,1,2; bank_addr 1,1,2,2; glb_sel=PSUM.
- cmd num 0 → no bank_we; done pulses 1 cycle after cmd handshake; cmd_ready back high the cycle after.
- wr_stall high for 3 cycles mid-load with s_valid held → s_ready=0 and no writes during the stall; the word after the stall is written once with correct data and address.
- base 2^17-2, num 4 → writes to flat addresses 131070, 131071, 0, 1 (bank 2,3,0,1; rows 32767, 32767, 0, 0).
- rst asserted after 3 of 10 words → next cycle bank_we=0, busy=0, cmd_ready=1. A new cmd then loads correctly. With GLB_LOADER_CHECKSUM_EN, words 0x0001, 0x0010, 0x0100 give checksum 0x0111 at done.
